signed_cast_rnd: RTL
====================

SIGNED_CAST_RND -- requirements
Module: signed_cast_rnd

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4: number of parallel signed lanes.
REQ-002 SHALL have parameter DIN_WIDTH, default 16: input lane width, two's complement.
REQ-003 SHALL have parameter DIN_POINT, default 8: input fractional bits.
REQ-004 SHALL have parameter DOUT_WIDTH, default 12: output lane width.
REQ-005 SHALL have parameter DOUT_POINT, default 6: output fractional bits.
REQ-006 SHALL have parameter SYMMETRIC_SAT, default 0: when 1, the negative clamp is -(2^(DOUT_WIDTH-1)-1).
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port round_mode, input, 2 bits: 0 truncate (floor), 1 round half up, 2 convergent (half to even), 3 reserved and treated as 0.
REQ-010 SHALL have port din, input, N_CHANNELS*DIN_WIDTH bits: lane k at [k*DIN_WIDTH+:DIN_WIDTH].
REQ-011 SHALL have port din_valid, input, 1 bit: input beat valid.
REQ-012 SHALL have port din_ready, output, 1 bit: block accepts a beat this cycle.
REQ-013 SHALL have port dout, output, N_CHANNELS*DOUT_WIDTH bits: converted lanes, same packing as din.
REQ-014 SHALL have port dout_valid, output, 1 bit: output beat valid.
REQ-015 SHALL have port dout_ready, input, 1 bit: downstream accepts the beat.
REQ-016 SHALL have port warning, output, 2*N_CHANNELS bits: per-lane code at [2k+:2] (0 ok, 1 overflow clamp, 2 underflow clamp), aligned with dout.
REQ-017 SHALL have port sat_count, output, 16 bits: count of output beats with any lane clamped.
REQ-018 SHALL have port clr_count, input, 1 bit: synchronous clear of sat_count.

Function
REQ-019 SHALL implement a 2-stage pipeline: stage 1 rounds, stage 2 saturates and registers the outputs; latency is 2 cycles from acceptance to dout_valid when unstalled.
REQ-020 SHALL define advance = ~dout_valid | dout_ready, and din_ready = advance & ~rst.
REQ-021 SHALL accept a beat iff din_valid & din_ready; a beat leaves iff dout_valid & dout_ready.
REQ-022 SHALL hold both stages, dout, and warning stable while dout_valid & ~dout_ready, with no beat lost or duplicated.
REQ-023 SHALL sample round_mode together with the accepted beat; round_mode changes affect only later beats.
REQ-024 SHALL, when D = DIN_POINT-DOUT_POINT > 0, compute in DIN_WIDTH+1 bits, then arithmetic right shift by D: mode 0 adds 0, mode 1 adds 2^(D-1), mode 2 adds 2^(D-1)-1+bit D of the input.
REQ-025 SHALL, when D <= 0, ignore round_mode and left-shift by -D, zero filling the fraction.
REQ-026 SHALL saturate the whole rounded value, not only the integer part: above 2^(DOUT_WIDTH-1)-1 it clamps to that value with code 1; below the minimum (-2^(DOUT_WIDTH-1), or -(2^(DOUT_WIDTH-1)-1) if SYMMETRIC_SAT) it clamps to the minimum with code 2.
REQ-027 SHALL process all lanes independently and identically within the same beat.
REQ-028 SHALL increment sat_count by 1 per transferred output beat (dout_valid & dout_ready) with any nonzero warning, and hold at 16'hFFFF without wrapping.
REQ-029 SHALL give clr_count priority over a simultaneous increment; the result is 0.

Reset
REQ-030 SHALL, while rst is high, clear both stage valids, dout, warning, and sat_count to 0 and drive din_ready 0.
REQ-031 SHALL discard in-flight beats on a reset asserted mid-stream; dout_valid is 0 on the cycle after rst is sampled high.
REQ-032 SHALL drive din_ready 1 on the first cycle after rst deasserts, given dout_valid is 0.

Verification (N_CHANNELS=2, DIN 8/4, DOUT 6/2, dout_ready=1 unless stated)
REQ-033 SHALL cover rounding: lane 0x13 -> 0x04 in mode 0 and 0x05 in mode 1; lane 0x12 -> 0x05 in mode 1 and 0x04 in mode 2; lane 0x16 -> 0x06 in mode 2; all warning 0, dout_valid 2 cycles after acceptance.
REQ-034 SHALL cover saturation: 0x7F in mode 1 -> 0x1F with warning 1; 0x80 in mode 0 -> 0x20 with warning 0; 0x80 with SYMMETRIC_SAT=1 -> 0x21 with warning 2; sat_count increments once per clamped beat.
REQ-035 SHALL cover backpressure: a stream of 8 beats with dout_ready toggling randomly -> all 8 outputs in order, held stable while stalled, din_ready low only when stage 2 is full and stalled.
REQ-036 SHALL cover a mid-stream reset with 2 beats in flight -> dout_valid 0 and sat_count 0 the next cycle; the next accepted beat emerges after 2 cycles.
REQ-037 SHALL cover the counter: drive it to 16'hFFFF and send another clamped beat -> stays 16'hFFFF; clr_count with a simultaneous clamped beat -> 0.
REQ-038 SHALL cover widening, DIN 8/4 to DOUT 12/6: 0x93 -> 0xE4C; round_mode has no effect.

Source files
------------

// File: rtl/signed_cast_rnd.sv
// Per-lane signed fixed-point recast: stage 1 rounds (or widens), stage 2 saturates.
// Both stages advance together under a single ready/valid handshake.
module signed_cast_rnd #(
    parameter int N_CHANNELS    = 4,
    parameter int DIN_WIDTH     = 16,
    parameter int DIN_POINT     = 8,
    parameter int DOUT_WIDTH    = 12,
    parameter int DOUT_POINT    = 6,
    parameter int SYMMETRIC_SAT = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       round_mode,
    input  logic [N_CHANNELS*DIN_WIDTH-1:0]  din,
    input  logic                             din_valid,
    output logic                             din_ready,
    output logic [N_CHANNELS*DOUT_WIDTH-1:0] dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic [2*N_CHANNELS-1:0]          warning,
    output logic [15:0]                      sat_count,
    input  logic                             clr_count
);

    localparam int D    = DIN_POINT - DOUT_POINT;
    localparam int SH   = (D > 0) ? D : 0;
    localparam int LS   = (D < 0) ? -D : 0;
    localparam int RW   = DIN_WIDTH + 1 + LS;
    localparam int CW   = ((RW > DOUT_WIDTH) ? RW : DOUT_WIDTH) + 1;
    localparam int SHM1 = (SH > 0) ? SH - 1 : 0;
    localparam int BI   = (SH < DIN_WIDTH) ? SH : DIN_WIDTH - 1;

    localparam logic [RW-1:0]        HALF     = RW'(1) << SHM1;
    localparam logic signed [CW-1:0] MAX_V    = $signed({{(CW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}});
    localparam logic signed [CW-1:0] MIN_FULL = ~MAX_V;
    localparam logic signed [CW-1:0] MIN_V    = (SYMMETRIC_SAT != 0) ? MIN_FULL + CW'(1) : MIN_FULL;

    // Narrowing: bias then arithmetic shift; the extra MSB keeps the biased sum from wrapping.
    function automatic logic signed [RW-1:0] round_lane(input logic signed [DIN_WIDTH-1:0] x,
                                                        input logic [1:0] mode);
        logic signed [RW-1:0] ext;
        logic [RW-1:0]        bias;
        ext  = {{(RW-DIN_WIDTH){x[DIN_WIDTH-1]}}, x};
        bias = '0;
        if (D > 0) begin
            case (mode)
                2'd1:    bias = HALF;
                2'd2:    bias = HALF - RW'(1) + RW'(x[BI]);
                default: bias = '0;
            endcase
            return (ext + $signed(bias)) >>> SH;
        end
        return ext <<< LS;
    endfunction

    // Returns {warning code, clamped lane}.
    function automatic logic [DOUT_WIDTH+1:0] saturate(input logic signed [RW-1:0] v);
        logic signed [CW-1:0] ext;
        ext = {{(CW-RW){v[RW-1]}}, v};
        if (ext > MAX_V) return {2'd1, MAX_V[DOUT_WIDTH-1:0]};
        if (ext < MIN_V) return {2'd2, MIN_V[DOUT_WIDTH-1:0]};
        return {2'd0, ext[DOUT_WIDTH-1:0]};
    endfunction

    logic                             advance;
    logic [N_CHANNELS*RW-1:0]         rnd_p1_q, rnd_p1_d;
    logic                             vld_p1_q, vld_p1_d;
    logic [N_CHANNELS*DOUT_WIDTH-1:0] dout_p2_q, dout_p2_d;
    logic [2*N_CHANNELS-1:0]          warn_p2_q, warn_p2_d;
    logic                             vld_p2_q, vld_p2_d;
    logic [15:0]                      sat_cnt_q, sat_cnt_d;

    assign advance   = ~vld_p2_q | dout_ready;
    assign din_ready = advance & ~rst;

    always_comb begin
        rnd_p1_d  = rnd_p1_q;
        vld_p1_d  = vld_p1_q;
        dout_p2_d = dout_p2_q;
        warn_p2_d = warn_p2_q;
        vld_p2_d  = vld_p2_q;
        sat_cnt_d = sat_cnt_q;
        if (advance) begin
            // stage 1: round the incoming beat with the mode sampled alongside it
            vld_p1_d = din_valid;
            for (int k = 0; k < N_CHANNELS; k++) begin
                rnd_p1_d[k*RW +: RW] = round_lane(din[k*DIN_WIDTH +: DIN_WIDTH], round_mode);
            end
            // stage 2: saturate and register the outputs
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                for (int k = 0; k < N_CHANNELS; k++) begin
                    {warn_p2_d[2*k +: 2], dout_p2_d[k*DOUT_WIDTH +: DOUT_WIDTH]} =
                        saturate(rnd_p1_q[k*RW +: RW]);
                end
            end
        end
        if (clr_count) begin
            sat_cnt_d = '0;
        end else if (vld_p2_q && dout_ready && (|warn_p2_q) && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            dout_p2_q <= '0;
            warn_p2_q <= '0;
            sat_cnt_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            dout_p2_q <= dout_p2_d;
            warn_p2_q <= warn_p2_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rnd_p1_q <= rnd_p1_d;
    end

    assign dout       = dout_p2_q;
    assign dout_valid = vld_p2_q;
    assign warning    = warn_p2_q;
    assign sat_count  = sat_cnt_q;

endmodule
